// File: rtl/dcc_packet_serializer.sv
// -----------------------------------------------------------------------------
// dcc_packet_serializer
//
// Buffers one DCC packet (up to MAX_DATA data bytes plus a running XOR
// checksum). It then serializes the packet bit by bit to a downstream bit
// encoder. The encoder consumes the presented bit and signals this with a
// rising edge on ack. Between packets the serializer keeps presenting '1',
// which forms the idle/preamble stream.
//
// Wire format per packet:
//     PREAMBLE_LEN ones, {0, byte[i] MSB first} for each data byte,
//     0, checksum MSB first, 1
//
// Ports
//     clk       in   single clock (also clocks the encoder prescaler)
//     reset_n   in   asynchronous, active-low reset
//     s_valid   in   upstream byte valid
//     s_data    in   [7:0] packet data byte
//     s_last    in   marks s_data as the final data byte of the packet
//     s_ready   out  a byte is accepted when s_valid && s_ready at clk rise
//     next_bit  out  bit presented to the encoder
//     ack       in   encoder level; each 0->1 transition consumes next_bit
//     busy      out  packet closed in the buffer or being transmitted
//     pkt_done  out  one-clk pulse when the end bit has been consumed
//     ovf_err   out  one-clk pulse when a packet is force-closed at MAX_DATA
//
// State table (decision taken on each advance event)
//     state     | meaning
//     PREAMBLE  | presenting preamble/idle ones, counting them in pre_cnt
//     START     | separator 0 presented; next event presents bit 7 of byte
//     DATA      | shifting out the current byte (data or checksum)
//     END       | end bit presented; next event closes out the packet
// -----------------------------------------------------------------------------
module dcc_packet_serializer #(
    parameter int PREAMBLE_LEN = 14,
    parameter int MAX_DATA     = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic       next_bit,
    input  logic       ack,
    output logic       busy,
    output logic       pkt_done,
    output logic       ovf_err
);

    localparam int NW = $clog2(MAX_DATA + 1);
    localparam int PW = $clog2(PREAMBLE_LEN + 1);

    typedef enum logic [1:0] {
        ST_PREAMBLE = 2'd0,
        ST_START    = 2'd1,
        ST_DATA     = 2'd2,
        ST_END      = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic            ack_q;
    logic            adv;

    logic [PW-1:0]   pre_cnt, pre_cnt_nxt, pre_inc;
    logic            pre_hit;
    logic [NW-1:0]   idx, idx_nxt;
    logic [2:0]      bit_cnt, bit_cnt_nxt;
    logic [6:0]      shreg, shreg_nxt;
    logic            next_bit_q, next_bit_nxt;
    logic            pkt_done_q, pkt_done_nxt;
    logic            clear_buf;

    logic [7:0]      buf_mem [MAX_DATA];
    logic [NW-1:0]   n;
    logic [7:0]      cks;
    logic            closed;
    logic            ovf_q;
    logic            accept;
    logic            at_limit;
    logic [7:0]      cur_byte;

    // ------------------------------------------------------------------
    // Advance event: one per ack pulse, however long ack stays high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack;
        end
    end

    assign adv = ack & ~ack_q;

    // ------------------------------------------------------------------
    // Upstream side / packet buffer
    // ------------------------------------------------------------------
    assign s_ready  = ~closed & ~pkt_done_q;
    assign busy     = closed | pkt_done_q;
    assign accept   = s_valid & s_ready;
    assign at_limit = (n == NW'(MAX_DATA - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n      <= '0;
            cks    <= '0;
            closed <= 1'b0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < MAX_DATA; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            ovf_q <= 1'b0;
            if (clear_buf) begin
                n      <= '0;
                cks    <= '0;
                closed <= 1'b0;
            end else if (accept) begin
                for (int i = 0; i < MAX_DATA; i++) begin
                    if (n == NW'(i)) begin
                        buf_mem[i] <= s_data;
                    end
                end
                cks <= cks ^ s_data;
                n   <= n + NW'(1);
                if (s_last || at_limit) begin
                    closed <= 1'b1;
                end
                ovf_q <= at_limit & ~s_last;
            end
        end
    end

    // Byte being serialized: data byte idx, or the checksum once idx == n.
    always_comb begin
        cur_byte = cks;
        for (int i = 0; i < MAX_DATA; i++) begin
            if ((idx < n) && (idx == NW'(i))) begin
                cur_byte = buf_mem[i];
            end
        end
    end

    // Saturating preamble count after this event's increment.
    assign pre_inc = (pre_cnt == PW'(PREAMBLE_LEN)) ? pre_cnt : pre_cnt + PW'(1);
    assign pre_hit = (pre_inc == PW'(PREAMBLE_LEN));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_PREAMBLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (adv) begin
            case (state)
                ST_PREAMBLE: if (pre_hit && closed) state_nxt = ST_START;
                ST_START:    state_nxt = ST_DATA;
                ST_DATA: begin
                    if (bit_cnt == 3'd0) begin
                        state_nxt = (idx < n) ? ST_START : ST_END;
                    end
                end
                ST_END:      state_nxt = ST_PREAMBLE;
                default:     state_nxt = ST_PREAMBLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs and serializer datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        pre_cnt_nxt  = pre_cnt;
        idx_nxt      = idx;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        next_bit_nxt = next_bit_q;
        pkt_done_nxt = 1'b0;
        clear_buf    = 1'b0;
        if (adv) begin
            case (state)
                ST_PREAMBLE: begin
                    pre_cnt_nxt  = pre_inc;
                    next_bit_nxt = ~(pre_hit & closed);
                end
                ST_START: begin
                    next_bit_nxt = cur_byte[7];
                    shreg_nxt    = cur_byte[6:0];
                    bit_cnt_nxt  = 3'd7;
                end
                ST_DATA: begin
                    if (bit_cnt != 3'd0) begin
                        next_bit_nxt = shreg[6];
                        shreg_nxt    = {shreg[5:0], 1'b0};
                        bit_cnt_nxt  = bit_cnt - 3'd1;
                    end else if (idx < n) begin
                        idx_nxt      = idx + NW'(1);
                        next_bit_nxt = 1'b0;
                    end else begin
                        next_bit_nxt = 1'b1;
                    end
                end
                ST_END: begin
                    // End bit is not part of the next preamble.
                    pkt_done_nxt = 1'b1;
                    clear_buf    = 1'b1;
                    pre_cnt_nxt  = '0;
                    idx_nxt      = '0;
                    next_bit_nxt = 1'b1;
                end
                default: begin
                    next_bit_nxt = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt    <= '0;
            idx        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            next_bit_q <= 1'b1;
            pkt_done_q <= 1'b0;
        end else begin
            pre_cnt    <= pre_cnt_nxt;
            idx        <= idx_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            next_bit_q <= next_bit_nxt;
            pkt_done_q <= pkt_done_nxt;
        end
    end

    assign next_bit = next_bit_q;
    assign pkt_done = pkt_done_q;
    assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_dcc_packet_serializer.sv
module tb_dcc_packet_serializer;

    localparam int PL = 14;
    localparam int MD = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
    logic       ack = 1'b0;
    logic       s_ready, next_bit, busy, pkt_done, ovf_err;

    dcc_packet_serializer #(.PREAMBLE_LEN(PL), .MAX_DATA(MD)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .next_bit (next_bit),
        .ack      (ack),
        .busy     (busy),
        .pkt_done (pkt_done),
        .ovf_err  (ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             pre_idle;
        int             nb;
        logic [4:0][7:0] d;
        bit             last;
        int             w;
        int             exp_ovf;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int pre_seen = 0;
    int done_cnt = 0;
    int ovf_cnt = 0;
    bit exp_q[$];

    always @(posedge clk) begin
        if (pkt_done) done_cnt++;
        if (ovf_err)  ovf_cnt++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Consume the presented bit with an ack pulse w cycles wide and compare
    // it against the scoreboard (idle stream is all ones).
    task automatic consume(input int w);
        logic b;
        bit   e;
        @(negedge clk);
        b = next_bit;
        ack = 1'b1;
        repeat (w) @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (exp_q.size() == 0) pre_seen = 0;
        end else begin
            e = 1'b1;
            if (pre_seen < PL) pre_seen++;
        end
        check("bit", b, e);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input logic exp_rdy);
        @(negedge clk);
        check("s_ready", s_ready, exp_rdy);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Expected wire bits; the currently presented one is always consumed
    // before a start bit, so at least one preamble one remains.
    task automatic queue_packet(input vec_t v);
        int         ones;
        logic [7:0] c;
        ones = PL - pre_seen;
        if (ones < 1) ones = 1;
        for (int i = 0; i < ones; i++) exp_q.push_back(1'b1);
        c = 8'h00;
        for (int i = 0; i < v.nb; i++) begin
            exp_q.push_back(1'b0);
            for (int b = 7; b >= 0; b--) exp_q.push_back(v.d[i][b]);
            c = c ^ v.d[i];
        end
        exp_q.push_back(1'b0);
        for (int b = 7; b >= 0; b--) exp_q.push_back(c[b]);
        exp_q.push_back(1'b1);
    endtask

    task automatic load_packet(input vec_t v);
        for (int i = 0; i < v.pre_idle; i++) consume(1);
        for (int i = 0; i < v.nb; i++) send_byte(v.d[i], v.last && (i == v.nb - 1), 1'b1);
        if (v.nb == MD && !v.last) send_byte(8'hEE, 1'b1, 1'b0);
        queue_packet(v);
        @(negedge clk);
        check("busy_closed", busy, 1'b1);
        check("s_ready_closed", s_ready, 1'b0);
    endtask

    task automatic run_packet(input vec_t v);
        int d0, o0, total;
        d0 = done_cnt;
        o0 = ovf_cnt;
        load_packet(v);
        total = exp_q.size();
        for (int k = 0; k < total; k++) consume(v.w);
        @(negedge clk);
        check("pkt_done_cnt", done_cnt - d0, 1);
        check("ovf_cnt", ovf_cnt - o0, v.exp_ovf);
        check("s_ready_after", s_ready, 1'b1);
        check("busy_after", busy, 1'b0);
    endtask

    vec_t vt[5];
    vec_t vr;

    initial begin
        vt[0] = '{pre_idle: 0,  nb: 2, d: {8'h00, 8'h00, 8'h00, 8'h3F, 8'h03}, last: 1, w: 1, exp_ovf: 0};
        vt[1] = '{pre_idle: 5,  nb: 1, d: {8'h00, 8'h00, 8'h00, 8'h00, 8'hA5}, last: 1, w: 2, exp_ovf: 0};
        vt[2] = '{pre_idle: 0,  nb: 5, d: {8'h10, 8'h08, 8'h04, 8'h02, 8'h01}, last: 0, w: 1, exp_ovf: 1};
        vt[3] = '{pre_idle: 20, nb: 5, d: {8'hC3, 8'h7E, 8'h80, 8'h00, 8'hFF}, last: 1, w: 8, exp_ovf: 0};
        vt[4] = '{pre_idle: 13, nb: 3, d: {8'h00, 8'h00, 8'hBE, 8'hAD, 8'hDE}, last: 1, w: 3, exp_ovf: 0};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_next_bit", next_bit, 1'b1);
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_pkt_done", pkt_done, 1'b0);
        check("rst_ovf_err", ovf_err, 1'b0);
        reset_n = 1'b1;

        // Idle: 40 acks, all ones, never busy
        for (int i = 0; i < 40; i++) begin
            consume(1);
            check("idle_busy", busy, 1'b0);
            check("idle_s_ready", s_ready, 1'b1);
        end

        // Fresh preamble count for the table
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        pre_seen = 0;

        for (int i = 0; i < 5; i++) run_packet(vt[i]);

        // Reset during DATA discards the packet; next one gets a full preamble
        vr = '{pre_idle: 0, nb: 2, d: {8'h00, 8'h00, 8'h00, 8'hAA, 8'h55}, last: 1, w: 1, exp_ovf: 0};
        load_packet(vr);
        for (int k = 0; k < PL + 5; k++) consume(1);
        @(negedge clk);
        check("pre_reset_next_bit", next_bit, vr.d[0][3]);
        reset_n = 1'b0;
        #1;
        check("mid_rst_next_bit", next_bit, 1'b1);
        check("mid_rst_s_ready", s_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        exp_q.delete();
        pre_seen = 0;
        @(negedge clk);
        reset_n = 1'b1;
        vr = '{pre_idle: 0, nb: 1, d: {8'h00, 8'h00, 8'h00, 8'h00, 8'h12}, last: 1, w: 1, exp_ovf: 0};
        run_packet(vr);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dcc_packet_serializer.md
DCC_PACKET_SERIALIZER -- requirements
Module: dcc_packet_serializer

Interface
REQ-001 Parameter PREAMBLE_LEN, default 14: number of consecutive '1' bits consumed before each packet start bit; legal values are 14 to 31.
REQ-002 Parameter MAX_DATA, default 5: maximum data bytes per packet, excluding the checksum.
REQ-003 clk  in  1: single clock for all logic; the same clock drives the downstream bit encoder's prescaler.
REQ-004 reset_n  in  1: reset is asynchronous and active-low.
REQ-005 s_valid  in  1: upstream byte valid.
REQ-006 s_data  in  8: packet data byte (address, instruction, ...).
REQ-007 s_last  in  1: qualifies s_data as the final data byte of the packet.
REQ-008 s_ready  out  1: serializer accepts a byte when s_valid && s_ready at a clk rising edge.
REQ-009 next_bit  out  1: bit presented to the bit encoder.
REQ-010 ack  in  1: encoder level; each 0->1 transition means "presented bit consumed".
REQ-011 busy  out  1: a packet is closed in the buffer or is being transmitted.
REQ-012 pkt_done  out  1: one-clk pulse when the packet end bit is consumed.
REQ-013 ovf_err  out  1: one-clk pulse when a packet is force-closed at MAX_DATA bytes.

Function
REQ-014 ack SHALL be registered once in the clk domain; an advance event is defined as ack=1 with the registered ack=0, so exactly one event occurs per ack pulse regardless of pulse width.
REQ-015 next_bit SHALL be updated in the clk cycle that follows the advance event, and SHALL be held stable between events.
REQ-016 Buffer SHALL hold MAX_DATA bytes, a byte count n, and a running XOR checksum; each accepted byte is stored at index n, XORed into the checksum, and n is incremented.
REQ-017 The packet SHALL close on an accepted byte with s_last=1, or on the MAX_DATA-th accepted byte; a close at MAX_DATA with s_last=0 pulses ovf_err in the cycle after acceptance.
REQ-018 s_ready SHALL be 1 while the buffer is open, and SHALL be 0 from the cycle after close until the cycle after pkt_done.
REQ-019 busy SHALL be 1 from close until the pkt_done cycle inclusive.
REQ-020 The state machine SHALL have the states PREAMBLE, START, DATA and END; transitions occur only on advance events.
REQ-021 In PREAMBLE, next_bit=1 and pre_cnt increments, saturating at PREAMBLE_LEN.
  - If pre_cnt reaches PREAMBLE_LEN after the increment and the packet is closed: next_bit=0 and the state becomes START.
  - Otherwise: remain in PREAMBLE and keep presenting 1, which continues the idle/preamble stream.
REQ-022 In START, the serializer SHALL present bit 7 of byte[idx] (or of the checksum when idx=n), then go to DATA with bit_cnt=7.
REQ-023 In DATA with bit_cnt>0: present the next lower bit and decrement bit_cnt; bytes are sent MSB first.
REQ-024 In DATA with bit_cnt=0 and idx<n: increment idx, present 0 (separator), and go to START.
REQ-025 In DATA with bit_cnt=0 and idx=n (checksum sent): present 1 (end bit) and go to END.
REQ-026 In END, the serializer SHALL pulse pkt_done, clear the buffer (n=0, checksum=0, idx=0), set pre_cnt=0, present 1 and go to PREAMBLE.
  - The end bit does not count toward the next preamble.
REQ-027 Each packet's wire format SHALL be: PREAMBLE_LEN ones, then for each data byte a 0 followed by 8 bits, then a 0, the 8 checksum bits and a final 1.
  - Total bits after the preamble = 9*(n+1)+1.
REQ-028 A packet closing while pre_cnt<PREAMBLE_LEN SHALL wait for the full preamble.
  - A packet closing after the preamble has saturated starts on the next advance event.
REQ-029 A byte accepted in the same cycle as an advance event SHALL not affect that event's decision; it is considered from the next event.
REQ-030 idx, bit_cnt, pre_cnt and n SHALL be sized to cover their maxima without wrap-around.

Reset
REQ-031 While reset_n=0, outputs SHALL be: next_bit=1, s_ready=1, busy=0, pkt_done=0, ovf_err=0.
  - Internal state: PREAMBLE, pre_cnt=0, n=0, checksum=0, idx=0, bit_cnt=0, registered ack=0.
REQ-032 Assertion of reset mid-packet SHALL discard the buffered packet; after release, a full PREAMBLE_LEN preamble precedes any new packet.

Verification
REQ-033 Reset followed by no bytes and 40 ack pulses -> next_bit is constantly 1, busy=0, s_ready=1.
REQ-034 Bytes 0x03 then 0x3F with s_last, then acks -> 14 ones, 0, 00000011, 0, 00111111, 0, 00111100, 1; pkt_done once; s_ready back to 1.
REQ-035 Five bytes with s_last=0 on all -> ovf_err one pulse, s_ready=0, sixth byte not accepted, 55 bits after the preamble.
REQ-036 Packet closed when pre_cnt=5 -> start bit appears only after 14 ones are consumed in total.
REQ-037 Ack held high for 8 clk cycles -> exactly one bit advance per pulse.
REQ-038 reset_n pulsed low during the DATA phase -> next_bit=1 immediately, s_ready=1, and the next packet is preceded by 14 ones.
